// File: rtl/tcdm_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_rr_arbiter
// Purpose  : Round-robin arbiter in front of one single-ported TCDM SRAM bank.
//            Issues at most one access per cycle. Read data comes back in
//            order through a 2-entry response FIFO, tagged with the requester
//            index and metadata. A credit counter keeps the FIFO from
//            overflowing.
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_bank_rr_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 8,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MetaWidth    = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumIn-1:0]                        req_valid_i,
    output logic [NumIn-1:0]                        req_ready_o,
    input  logic [NumIn-1:0][AddrMemWidth-1:0]      req_addr_i,
    input  logic [NumIn-1:0]                        req_wen_i,
    input  logic [NumIn-1:0][DataWidth/8-1:0]       req_be_i,
    input  logic [NumIn-1:0][DataWidth-1:0]         req_wdata_i,
    input  logic [NumIn-1:0][MetaWidth-1:0]         req_meta_i,
    output logic                                    bank_req_o,
    output logic                                    bank_we_o,
    output logic [AddrMemWidth-1:0]                 bank_addr_o,
    output logic [DataWidth/8-1:0]                  bank_be_o,
    output logic [DataWidth-1:0]                    bank_wdata_o,
    input  logic [DataWidth-1:0]                    bank_rdata_i,
    output logic                                    resp_valid_o,
    input  logic                                    resp_ready_i,
    output logic [$clog2(NumIn)-1:0]                resp_idx_o,
    output logic [DataWidth-1:0]                    resp_rdata_o,
    output logic [MetaWidth-1:0]                    resp_meta_o
);

    localparam int unsigned IdxWidth = $clog2(NumIn);

    logic [IdxWidth-1:0]  ptr;
    logic [1:0]           credit;
    logic                 pop;
    logic                 read_ok;
    logic [NumIn-1:0]     eligible;
    logic                 gnt_valid;
    logic [IdxWidth-1:0]  gnt_idx;
    logic [IdxWidth-1:0]  cand;
    logic                 read_grant;

    // in-flight read tag, waiting one cycle for the SRAM data
    logic                 infl_valid;
    logic [IdxWidth-1:0]  infl_idx;
    logic [MetaWidth-1:0] infl_meta;

    // 2-entry response FIFO storage
    logic [DataWidth-1:0] fifo_rdata [2];
    logic [IdxWidth-1:0]  fifo_idx   [2];
    logic [MetaWidth-1:0] fifo_meta  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    assign pop     = resp_valid_o & resp_ready_i;
    // a pop in this cycle frees the slot the new read will eventually need
    assign read_ok = (credit != 2'd0) | pop;
    // nothing is granted while reset is held so outputs stay quiet
    assign eligible = req_valid_i & (req_wen_i | {NumIn{read_ok}}) & {NumIn{rst_ni}};

    // round-robin search over eligible requesters starting at ptr
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NumIn; off++) begin
            cand = ptr + off[IdxWidth-1:0];
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign read_grant = gnt_valid & ~req_wen_i[gnt_idx];

    // grant handshake and bank request mux, all in the grant cycle
    always_comb begin
        req_ready_o  = '0;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        if (gnt_valid) begin
            req_ready_o[gnt_idx] = 1'b1;
            bank_req_o           = 1'b1;
            bank_we_o            = req_wen_i[gnt_idx];
            bank_addr_o          = req_addr_i[gnt_idx];
            bank_be_o            = req_be_i[gnt_idx];
            bank_wdata_o         = req_wdata_i[gnt_idx];
        end
    end

    // round-robin pointer and credit bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr    <= '0;
            credit <= 2'd2;
        end else begin
            if (gnt_valid) begin
                ptr <= gnt_idx + 1'b1;
            end
            if (read_grant && !pop) begin
                credit <= credit - 2'd1;
            end else if (!read_grant && pop) begin
                credit <= credit + 2'd1;
            end
        end
    end

    // capture the tag of a granted read for the data-return cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_valid <= 1'b0;
            infl_idx   <= '0;
            infl_meta  <= '0;
        end else begin
            infl_valid <= read_grant;
            if (read_grant) begin
                infl_idx  <= gnt_idx;
                infl_meta <= req_meta_i[gnt_idx];
            end
        end
    end

    // response FIFO: push returning read data, pop on accepted response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_rdata[i] <= '0;
                fifo_idx[i]   <= '0;
                fifo_meta[i]  <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (infl_valid) begin
                fifo_rdata[wr_ptr] <= bank_rdata_i;
                fifo_idx[wr_ptr]   <= infl_idx;
                fifo_meta[wr_ptr]  <= infl_meta;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (infl_valid && !pop) begin
                count <= count + 2'd1;
            end else if (!infl_valid && pop) begin
                count <= count - 2'd1;
            end
        end
    end

    assign resp_valid_o = (count != 2'd0);
    assign resp_idx_o   = fifo_idx[rd_ptr];
    assign resp_rdata_o = fifo_rdata[rd_ptr];
    assign resp_meta_o  = fifo_meta[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_bank_rr_arbiter
// Purpose  : Directed self-checking bench for tcdm_bank_rr_arbiter with a
//            behavioural 1-cycle-latency SRAM bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_rr_arbiter;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [3:0]            req_valid;
    logic [3:0]            req_ready;
    logic [3:0][7:0]       req_addr;
    logic [3:0]            req_wen;
    logic [3:0][3:0]       req_be;
    logic [3:0][31:0]      req_wdata;
    logic [3:0][7:0]       req_meta;
    logic                  bank_req;
    logic                  bank_we;
    logic [7:0]            bank_addr;
    logic [3:0]            bank_be;
    logic [31:0]           bank_wdata;
    logic [31:0]           bank_rdata = 32'h0;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_idx;
    logic [31:0]           resp_rdata;
    logic [7:0]            resp_meta;

    int total = 0;
    int bad   = 0;

    logic [31:0] sram [256];
    logic        sram_loaded = 1'b0;

    tcdm_bank_rr_arbiter #(
        .NumIn        (4),
        .AddrMemWidth (8),
        .DataWidth    (32),
        .MetaWidth    (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_wen_i    (req_wen),
        .req_be_i     (req_be),
        .req_wdata_i  (req_wdata),
        .req_meta_i   (req_meta),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_be_o    (bank_be),
        .bank_wdata_o (bank_wdata),
        .bank_rdata_i (bank_rdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_idx_o   (resp_idx),
        .resp_rdata_o (resp_rdata),
        .resp_meta_o  (resp_meta)
    );

    always #5 clk = ~clk;

    // SRAM bank model: preloaded on the first edge, then byte-masked writes
    // and registered reads
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int a = 0; a < 256; a++) sram[a] <= 32'hC0DE0000 | 32'(a);
            sram[5]     <= 32'hDEADBEEF;
            sram[16]    <= 32'hCAFEF00D;
            sram_loaded <= 1'b1;
        end else if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be[b]) sram[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
            end else begin
                bank_rdata <= sram[bank_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni     = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_wen    = '0;
        req_be     = '0;
        req_wdata  = '0;
        req_meta   = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_ready",  req_ready,  4'b0000);
        chk("rst_bank",   bank_req,   1'b0);
        chk("rst_we",     bank_we,    1'b0);
        chk("rst_valid",  resp_valid, 1'b0);
        chk("rst_rdata",  resp_rdata, 32'h0);
        chk("rst_meta",   resp_meta,  8'h0);
        chk("rst_credit", dut.credit, 2'd2);
        chk("rst_ptr",    dut.ptr,    2'd0);
        rst_ni = 1'b1;
        tick();

        // single read: requester 2, addr 0x05, meta 0x3C
        req_valid   = 4'b0100;
        req_wen     = 4'b0000;
        req_addr[2] = 8'h05;
        req_meta[2] = 8'h3C;
        #1;
        chk("rd1_gnt",   req_ready, 4'b0100);
        chk("rd1_bank",  bank_req,  1'b1);
        chk("rd1_we",    bank_we,   1'b0);
        chk("rd1_addr",  bank_addr, 8'h05);
        tick();
        req_valid = '0;
        #1;
        chk("rd1_early", resp_valid, 1'b0);
        tick();
        chk("rd1_valid", resp_valid, 1'b1);
        chk("rd1_idx",   resp_idx,   2'd2);
        chk("rd1_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd1_meta",  resp_meta,  8'h3C);
        resp_ready = 1'b1;
        tick();
        chk("rd1_drain", resp_valid, 1'b0);

        // fairness: all four read continuously, responses accepted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 8'(8'h20 + i);
            req_meta[i] = 8'(8'h40 + i);
        end
        req_wen    = 4'b0000;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("fair_gnt", req_ready, 4'b0001 << (c % 4));
            if (c >= 2) begin
                chk("fair_valid", resp_valid, 1'b1);
                chk("fair_idx",   resp_idx,   (c - 2) % 4);
                chk("fair_rdata", resp_rdata, 32'hC0DE0020 + ((c - 2) % 4));
                chk("fair_meta",  resp_meta,  8'h40 + ((c - 2) % 4));
            end
            tick();
        end
        req_valid = '0;
        for (int c = 8; c < 10; c++) begin
            #1;
            chk("fair_tail_valid", resp_valid, 1'b1);
            chk("fair_tail_idx",   resp_idx,   (c - 2) % 4);
            tick();
        end
        chk("fair_empty", resp_valid, 1'b0);

        // backpressure: reads from 0 and 1, write from 3, no response accept
        do_reset();
        req_addr[0]  = 8'h40;
        req_addr[1]  = 8'h41;
        req_addr[3]  = 8'h30;
        req_meta[0]  = 8'h10;
        req_meta[1]  = 8'h11;
        req_wdata[3] = 32'hAAAA5555;
        req_be[3]    = 4'b1111;
        req_wen      = 4'b1000;
        req_valid    = 4'b1011;
        #1;
        chk("bp_gnt0", req_ready, 4'b0001);
        tick();
        chk("bp_gnt1", req_ready, 4'b0010);
        tick();
        chk("bp_wr_gnt",   req_ready,  4'b1000);
        chk("bp_wr_we",    bank_we,    1'b1);
        chk("bp_wr_addr",  bank_addr,  8'h30);
        chk("bp_wr_data",  bank_wdata, 32'hAAAA5555);
        chk("bp_head_v",   resp_valid, 1'b1);
        chk("bp_head_idx", resp_idx,   2'd0);
        tick();
        req_valid = 4'b0011;
        #1;
        chk("bp_stall_gnt",  req_ready,  4'b0000);
        chk("bp_stall_bank", bank_req,   1'b0);
        chk("bp_credit0",    dut.credit, 2'd0);
        chk("bp_hold_idx",   resp_idx,   2'd0);
        chk("bp_hold_meta",  resp_meta,  8'h10);
        chk("bp_hold_rdata", resp_rdata, 32'hC0DE0040);
        tick();
        resp_ready = 1'b1;
        #1;
        chk("bp_pop_gnt", req_ready, 4'b0001);
        chk("bp_pop_idx", resp_idx,  2'd0);
        tick();
        req_valid = '0;
        #1;
        chk("bp_r1_valid", resp_valid, 1'b1);
        chk("bp_r1_idx",   resp_idx,   2'd1);
        chk("bp_r1_meta",  resp_meta,  8'h11);
        chk("bp_r1_rdata", resp_rdata, 32'hC0DE0041);
        tick();
        chk("bp_r2_valid", resp_valid, 1'b1);
        chk("bp_r2_idx",   resp_idx,   2'd0);
        chk("bp_r2_rdata", resp_rdata, 32'hC0DE0040);
        tick();
        chk("bp_empty",   resp_valid, 1'b0);
        chk("bp_credit2", dut.credit, 2'd2);

        // write then read, addr 0x10, byte-enabled low half
        do_reset();
        resp_ready   = 1'b1;
        req_addr[1]  = 8'h10;
        req_wdata[1] = 32'h12345678;
        req_be[1]    = 4'b0011;
        req_wen      = 4'b0010;
        req_valid    = 4'b0010;
        #1;
        chk("wr_gnt", req_ready, 4'b0010);
        chk("wr_we",  bank_we,   1'b1);
        chk("wr_be",  bank_be,   4'b0011);
        tick();
        req_wen     = 4'b0000;
        req_meta[1] = 8'h77;
        #1;
        chk("wr_rd_gnt", req_ready, 4'b0010);
        chk("wr_rd_we",  bank_we,   1'b0);
        tick();
        req_valid = '0;
        #1;
        chk("wr_rd_early", resp_valid, 1'b0);
        tick();
        chk("wr_rd_valid", resp_valid, 1'b1);
        chk("wr_rd_idx",   resp_idx,   2'd1);
        chk("wr_rd_rdata", resp_rdata, 32'hCAFE5678);
        chk("wr_rd_meta",  resp_meta,  8'h77);
        tick();

        // mid-operation reset with two reads outstanding
        do_reset();
        req_addr[0] = 8'h50;
        req_addr[1] = 8'h51;
        req_addr[2] = 8'h52;
        req_wen     = 4'b0000;
        req_valid   = 4'b0011;
        tick();
        tick();
        req_valid = '0;
        #1;
        chk("mr_pre_valid",  resp_valid, 1'b1);
        chk("mr_pre_credit", dut.credit, 2'd0);
        rst_ni = 1'b0;
        #1;
        chk("mr_async_valid", resp_valid, 1'b0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("mr_post_valid",  resp_valid, 1'b0);
        chk("mr_post_credit", dut.credit, 2'd2);
        resp_ready = 1'b1;
        req_valid  = 4'b0101;
        #1;
        chk("mr_gnt0", req_ready, 4'b0001);
        tick();
        chk("mr_gnt2",   req_ready,  4'b0100);
        chk("mr_nostale", resp_valid, 1'b0);
        tick();
        req_valid = '0;
        #1;
        chk("mr_r0_valid", resp_valid, 1'b1);
        chk("mr_r0_idx",   resp_idx,   2'd0);
        chk("mr_r0_rdata", resp_rdata, 32'hC0DE0050);
        tick();
        chk("mr_r2_valid", resp_valid, 1'b1);
        chk("mr_r2_idx",   resp_idx,   2'd2);
        chk("mr_r2_rdata", resp_rdata, 32'hC0DE0052);
        tick();
        chk("mr_empty", resp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
